page_frame_tx: RTL

PAGE_FRAME_TX -- requirements
Module: page_frame_tx

---
 rtl/page_frame_tx_pkg.sv | 55 +++++
 rtl/page_frame_tx_if.sv | 30 +++
 rtl/page_frame_tx_frame_byte_timer.sv | 32 +++
 rtl/page_frame_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/page_frame_tx_pkg.sv
// Shared constants for the page frame transmitter and the command parser:
// frame header bytes, trailer default, widths and FSM encodings.
package page_frame_tx_pkg;

   localparam int ADDR_W = 15;
   localparam int LEN_W  = 16;

   // Command parser bytes; the frame header reuses the sync and page command
   localparam logic [7:0] CMD_SYNC    = 8'hAA;
   localparam logic [7:0] CMD_PAGE_TX = 8'h02;
   localparam logic [7:0] CMD_STATUS  = 8'h03;

   localparam logic [7:0] HDR_SOF     = CMD_SYNC;
   localparam logic [7:0] HDR_CMD     = CMD_PAGE_TX;
   localparam logic [7:0] HDR_SUB     = 8'h16;
   localparam logic [7:0] HDR_MARK    = 8'hFF;
   localparam logic [7:0] TRAILER_DEF = 8'h55;

   localparam logic [LEN_W-1:0] PAGE_LEN_MAX = 16'd32768;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      HDR      = 4'd1,
      RD_REQ   = 4'd2,
      RD_WAIT  = 4'd3,
      SEND     = 4'd4,
      WAIT_ACK = 4'd5,
      CHK      = 4'd6,
      TAIL     = 4'd7,
      FIN      = 4'd8
   } ptx_state_e;

   // What the byte currently awaiting tx_done was
   typedef enum logic [1:0] {
      K_HDR  = 2'd0,
      K_PAY  = 2'd1,
      K_CHK  = 2'd2,
      K_TAIL = 2'd3
   } ptx_kind_e;

   function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    hdr_byte = HDR_SOF;
         2'd1:    hdr_byte = HDR_CMD;
         2'd2:    hdr_byte = HDR_SUB;
         2'd3:    hdr_byte = HDR_MARK;
         default: hdr_byte = HDR_SOF;
      endcase
   endfunction

   function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
      chk_fold = acc ^ b;
   endfunction

endpackage

// File: rtl/page_frame_tx_if.sv
// Bus bundle of the page frame transmitter: frame request, RAM read port,
// UART byte handshake and frame status.
interface page_frame_tx_if;
   import page_frame_tx_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] ram_base;
   logic [LEN_W-1:0]  page_len;
   logic              abort;
   logic [7:0]        ram_data;
   logic              ram_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_done;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, ram_base, page_len, abort, ram_data, tx_done,
      output ram_en, ram_addr, tx_data, tx_valid, busy, done, err
   );

   modport slave (
      output start, ram_base, page_len, abort, ram_data, tx_done,
      input  ram_en, ram_addr, tx_data, tx_valid, busy, done, err
   );

endinterface

// File: rtl/page_frame_tx_frame_byte_timer.sv
// Per-byte acknowledge timer: counts cycles while run is high and flags the
// last allowed cycle of the wait.
module frame_byte_timer
   import page_frame_tx_pkg::*;
#(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk_96M,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_r;

   // Counter restarts every time the wait is left
   always_ff @(posedge clk_96M or posedge rst) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (!run) begin
         cnt_r <= {W{1'b0}};
      end else begin
         cnt_r <= cnt_r + W'(1);
      end
   end

   assign expired = run && (cnt_r == LAST);

endmodule

// File: rtl/page_frame_tx.sv
// Page frame transmitter: streams header, a RAM payload, XOR checksum and
// trailer to a UART one byte at a time, waiting for tx_done after each.
module page_frame_tx
   import page_frame_tx_pkg::*;
#(
   parameter int unsigned TIMEOUT = 65535,
   parameter logic [7:0]  TRAILER = TRAILER_DEF
) (
   input logic            clk_96M,
   input logic            rst,
   page_frame_tx_if.master bus
);

   ptx_state_e        state_r, next_state_s;
   ptx_kind_e         kind_r;
   logic [1:0]        hdr_idx_r;
   logic [ADDR_W-1:0] addr_r, ram_addr_r;
   logic [LEN_W-1:0]  remain_r, len_clamp_s;
   logic [7:0]        chk_r, byte_r, tx_data_r;
   logic              ram_en_r, tx_valid_r, busy_r, done_r, err_r;
   logic              in_wait_s, expired_s;

   assign in_wait_s   = (state_r == WAIT_ACK);
   assign len_clamp_s = (bus.page_len > PAGE_LEN_MAX) ? PAGE_LEN_MAX : bus.page_len;

   frame_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_96M (clk_96M),
      .rst     (rst),
      .run     (in_wait_s),
      .expired (expired_s)
   );

   // State register
   always_ff @(posedge clk_96M or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; abort overrides everything, including a same-cycle tx_done
   always_comb begin
      next_state_s = state_r;
      if (bus.abort) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    if (bus.start) next_state_s = HDR; else next_state_s = IDLE;
            HDR, SEND, CHK, TAIL: next_state_s = WAIT_ACK;
            RD_REQ:  next_state_s = RD_WAIT;
            RD_WAIT: next_state_s = SEND;
            WAIT_ACK: begin
               if (bus.tx_done) begin
                  case (kind_r)
                     K_HDR:   if (hdr_idx_r != 2'd0)      next_state_s = HDR;
                              else if (remain_r != 16'd0) next_state_s = RD_REQ;
                              else                        next_state_s = CHK;
                     K_PAY:   if (remain_r != 16'd0) next_state_s = RD_REQ;
                              else                   next_state_s = CHK;
                     K_CHK:   next_state_s = TAIL;
                     K_TAIL:  next_state_s = FIN;
                     default: next_state_s = IDLE;
                  endcase
               end else if (expired_s) begin
                  next_state_s = IDLE;
               end else begin
                  next_state_s = WAIT_ACK;
               end
            end
            FIN:     next_state_s = IDLE;
            default: next_state_s = IDLE;
         endcase
      end
   end

   // Frame datapath and registered outputs; strobes follow the upcoming state
   always_ff @(posedge clk_96M or posedge rst) begin
      if (rst) begin
         kind_r     <= K_HDR;
         hdr_idx_r  <= 2'd0;
         addr_r     <= 15'd0;
         remain_r   <= 16'd0;
         chk_r      <= 8'd0;
         byte_r     <= 8'd0;
         tx_data_r  <= 8'd0;
         ram_addr_r <= 15'd0;
         ram_en_r   <= 1'b0;
         tx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         ram_en_r   <= (next_state_s == RD_REQ);
         tx_valid_r <= (next_state_s == WAIT_ACK) && !in_wait_s;
         busy_r     <= (next_state_s != IDLE);
         done_r     <= (next_state_s == FIN);
         err_r      <= expired_s && !bus.tx_done && !bus.abort;
         if (next_state_s == RD_REQ) ram_addr_r <= addr_r;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  addr_r    <= bus.ram_base;
                  remain_r  <= len_clamp_s;
                  hdr_idx_r <= 2'd0;
                  chk_r     <= 8'd0;
               end
            end
            HDR: begin
               tx_data_r <= hdr_byte(hdr_idx_r);
               kind_r    <= K_HDR;
               hdr_idx_r <= hdr_idx_r + 2'd1;
               // Only the last two header bytes are covered by the checksum
               if (hdr_idx_r[1]) chk_r <= chk_fold(chk_r, hdr_byte(hdr_idx_r));
            end
            RD_WAIT: byte_r <= bus.ram_data;
            SEND: begin
               tx_data_r <= byte_r;
               kind_r    <= K_PAY;
               chk_r     <= chk_fold(chk_r, byte_r);
               addr_r    <= addr_r + 15'd1;
               remain_r  <= remain_r - 16'd1;
            end
            CHK: begin
               tx_data_r <= chk_r;
               kind_r    <= K_CHK;
            end
            TAIL: begin
               tx_data_r <= TRAILER;
               kind_r    <= K_TAIL;
            end
            default: ;
         endcase
      end
   end

   assign bus.ram_en   = ram_en_r;
   assign bus.ram_addr = ram_addr_r;
   assign bus.tx_data  = tx_data_r;
   assign bus.tx_valid = tx_valid_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.err      = err_r;

endmodule
